sw_debounce: RTL and testbench

Input conditioner for the board's active-low DIP switches and pushbuttons; the input-side counterpart to the LED driver path. Each raw pin is synchronized into the 24 MHz HSOSC domain and debounced by a per-bit stability counter. The block presents clean active-high levels plus single-cycle change pulses to downstream logic, such as LED and display drivers.

---
 rtl/sw_debounce_pkg.sv | 14 +
 rtl/sw_debounce_bit.sv | 71 +++++++
 rtl/sw_debounce.sv | 61 ++++++
 tb/tb_sw_debounce.sv | 135 +++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// rtl/sw_debounce_pkg.sv - shared constants and counter sizing for the switch debouncer
package sw_debounce_pkg;

    localparam int unsigned CLK_HZ                  = 24_000_000;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 240000;

    // Counter must hold DEBOUNCE_CYCLES-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// rtl/sw_debounce_bit.sv - one switch bit: 2-flop synchronizer, stability counter, stable/changed flops
// SW_DEBOUNCE_EDGE_EN exposes next-state values so the top can register edge pulses in step.
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic stable_o,
    output logic changed_o
`ifdef SW_DEBOUNCE_EDGE_EN
    ,
    output logic stable_d_o,
    output logic changed_d_o
`endif
);

    localparam int unsigned     CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic          changed_q;
    logic          changed_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Pins are active-low; invert at entry so everything below is active-high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            stable_q  <= 1'b0;
            changed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= ~raw_i;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
        end
    end

    // Any agreement with the stable level discards the count in progress.
    always_comb begin
        stable_d  = stable_q;
        changed_d = 1'b0;
        cnt_d     = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d  = sync2_q;
                changed_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign stable_o  = stable_q;
    assign changed_o = changed_q;
`ifdef SW_DEBOUNCE_EDGE_EN
    assign stable_d_o  = stable_d;
    assign changed_d_o = changed_d;
`endif

endmodule

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - debounced active-high switch levels with change pulses
// SW_DEBOUNCE_EDGE_EN adds registered s_rise/s_fall pulses aligned with s_changed.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_raw,
    output logic [WIDTH-1:0] s_stable,
    output logic [WIDTH-1:0] s_changed
`ifdef SW_DEBOUNCE_EDGE_EN
    ,
    output logic [WIDTH-1:0] s_rise,
    output logic [WIDTH-1:0] s_fall
`endif
);

`ifdef SW_DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] changed_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk         (clk),
            .reset       (reset),
            .raw_i       (s_raw[i]),
            .stable_o    (s_stable[i]),
            .changed_o   (s_changed[i])
`ifdef SW_DEBOUNCE_EDGE_EN
            ,
            .stable_d_o  (stable_d[i]),
            .changed_d_o (changed_d[i])
`endif
        );
    end

`ifdef SW_DEBOUNCE_EDGE_EN
    // Classify from next-state so the edge pulses land in the same cycle as s_changed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= changed_d & stable_d;
            fall_q <= changed_d & ~stable_d;
        end
    end

    assign s_rise = rise_q;
    assign s_fall = fall_q;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - directed self-checking bench for sw_debounce (WIDTH=4, DEBOUNCE_CYCLES=8)
module tb_sw_debounce;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] s_raw;
    logic [3:0] s_stable;
    logic [3:0] s_changed;
`ifdef SW_DEBOUNCE_EDGE_EN
    logic [3:0] s_rise;
    logic [3:0] s_fall;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sw_debounce #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_raw     (s_raw),
        .s_stable  (s_stable),
        .s_changed (s_changed)
`ifdef SW_DEBOUNCE_EDGE_EN
        ,
        .s_rise    (s_rise),
        .s_fall    (s_fall)
`endif
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [3:0] stable_exp);
        chk({tag, "_stable"}, s_stable, stable_exp);
        chk({tag, "_changed"}, s_changed, 4'b0000);
`ifdef SW_DEBOUNCE_EDGE_EN
        chk({tag, "_rise"}, s_rise, 4'b0000);
        chk({tag, "_fall"}, s_fall, 4'b0000);
`endif
    endtask

    // Input was just driven: old level holds for 9 edges, new level and pulse after edge 10.
    task automatic accept(input string tag, input logic [3:0] old_v,
                          input logic [3:0] new_v, input logic [3:0] chg);
        for (int i = 0; i < 9; i++) begin
            step(1);
            chk_idle({tag, "_wait"}, old_v);
        end
        step(1);
        chk({tag, "_stable"}, s_stable, new_v);
        chk({tag, "_pulse"}, s_changed, chg);
`ifdef SW_DEBOUNCE_EDGE_EN
        chk({tag, "_rise"}, s_rise, chg & new_v);
        chk({tag, "_fall"}, s_fall, chg & ~new_v);
`endif
        step(1);
        chk_idle({tag, "_after"}, new_v);
    endtask

    initial begin
        reset = 1'b0;
        s_raw = 4'b0000;
        step(3);
        chk_idle("reset", 4'b0000);

        reset = 1'b1;
        accept("release", 4'b0000, 4'b1111, 4'b1111);

        s_raw = 4'b1111;
        accept("all_off", 4'b1111, 4'b0000, 4'b1111);

        s_raw[0] = 1'b0;
        accept("press0", 4'b0000, 4'b0001, 4'b0001);

        for (int t = 0; t < 12; t++) begin
            s_raw[1] = ~s_raw[1];
            for (int j = 0; j < 3; j++) begin
                step(1);
                chk_idle("bounce", 4'b0001);
            end
        end
        s_raw[1] = 1'b0;
        accept("bounce_end", 4'b0001, 4'b0011, 4'b0010);

        s_raw[2] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(1);
            chk_idle("glitch_low", 4'b0011);
        end
        s_raw[2] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk_idle("glitch_high", 4'b0011);
        end

        s_raw = 4'b1111;
        accept("rel_all", 4'b0011, 4'b0000, 4'b0011);

        s_raw = 4'b0000;
        accept("simul", 4'b0000, 4'b1111, 4'b1111);

        s_raw = 4'b1111;
        accept("rel_again", 4'b1111, 4'b0000, 4'b1111);

        s_raw[3] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(1);
            chk_idle("count3", 4'b0000);
        end
        reset = 1'b0;
        step(2);
        chk_idle("mid_reset", 4'b0000);
        reset = 1'b1;
        accept("after_reset", 4'b0000, 4'b1000, 4'b1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
